usr_ctrl: RTL

USR_CTRL -- requirements
Module: usr_ctrl

---
 rtl/usr_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/usr_ctrl.sv
// Command-driven shift register controller: LOAD, SHR and SHL, with ROR when
// built with USR_ROTATE_EN (otherwise op 11 completes immediately with err).
module usr_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             sin,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [3:0] WCNT    = 4'(WIDTH);

  state_t           state, state_nxt;
  logic [1:0]       op_r;
  logic [3:0]       rem_r;
  logic [WIDTH-1:0] data_r;
  logic             err_r;
  logic             op_supported;
  logic [3:0]       cnt_sat;

`ifdef USR_ROTATE_EN
  assign op_supported = 1'b1;
`else
  assign op_supported = (cmd_op != 2'b11);
`endif

  assign cnt_sat = (cmd_cnt > WCNT) ? WCNT : cmd_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD)                    state_nxt = LOAD;
          else if (!op_supported || cmd_cnt == 4'd0) state_nxt = DONE;
          else                                      state_nxt = SHIFT;
        end
      end
      LOAD:    state_nxt = DONE;
      SHIFT:   state_nxt = (rem_r <= 4'd1) ? DONE : SHIFT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    err       = (state == DONE) && err_r;
    mode      = 2'b00;
    case (state)
      LOAD:    mode = 2'b11;
      SHIFT:   mode = (op_r == OP_SHL) ? 2'b10 : 2'b01;
      default: mode = 2'b00;
    endcase
  end

  // Datapath: command latching in IDLE, register update in LOAD/SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r   <= '0;
      rem_r  <= '0;
      data_r <= '0;
      err_r  <= 1'b0;
      q      <= '0;
      sout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_r   <= cmd_op;
            rem_r  <= cnt_sat;
            data_r <= cmd_data;
            err_r  <= !op_supported;
          end
        end
        LOAD: q <= data_r;
        SHIFT: begin
          rem_r <= rem_r - 4'd1;
          case (op_r)
            OP_SHR: begin
              q    <= {sin, q[WIDTH-1:1]};
              sout <= q[0];
            end
            OP_SHL: begin
              q    <= {q[WIDTH-2:0], sin};
              sout <= q[WIDTH-1];
            end
`ifdef USR_ROTATE_EN
            default: begin
              q    <= {q[0], q[WIDTH-1:1]};
              sout <= q[0];
            end
`else
            default: begin
              q    <= q;
              sout <= sout;
            end
`endif
          endcase
        end
        DONE:    err_r <= 1'b0;
        default: err_r <= 1'b0;
      endcase
    end
  end

endmodule
